elevator_controller: RTL



---
 rtl/elevator_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/elevator_controller.sv
// elevator_controller: SCAN-style floor scheduler for a 4-stop car (optional ESTOP_EN adds estop input)
module elevator_controller #(
    parameter int TRAVEL_CYCLES = 50000000,
    parameter int DOOR_CYCLES   = 100000000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] up_or_down,
    input  logic [1:0] actual_stage,
`ifdef ESTOP_EN
    input  logic       estop,
`endif
    output logic [1:0] current_floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [3:0] pending,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

`ifndef ESTOP_EN
    logic estop;
    assign estop = 1'b0;
`endif

    state_t           state_q;
    logic [1:0]       floor_q, nf;
    logic [3:0]       pending_q, pending_d, set_v, clr_v;
    logic             last_dir_q, call_q, cap, reload, step, above, below, go_up, more;
    logic [CNT_W-1:0] travel_q, door_q;
    logic             unused_dir;

    assign unused_dir = up_or_down[1];

    function automatic logic [3:0] above_m(input logic [1:0] f);
        return 4'b1110 << f;
    endfunction

    function automatic logic [3:0] below_m(input logic [1:0] f);
        return (4'b0001 << f) - 4'd1;
    endfunction

    // Call edge capture, pending set/clear (clear wins) and scheduling terms
    always_comb begin
        cap       = up_or_down[0] & ~call_q;
        reload    = cap && state_q == DOOR_OPEN && actual_stage == floor_q;
        set_v     = (cap && !reload) ? 4'b0001 << actual_stage : 4'b0000;
        above     = |(pending_q & above_m(floor_q));
        below     = |(pending_q & below_m(floor_q));
        go_up     = above && (!below || last_dir_q);
        step      = !estop && (state_q == MOVE_UP || state_q == MOVE_DOWN) && travel_q == CNT_W'(TRAVEL_CYCLES - 1);
        nf        = state_q == MOVE_UP ? floor_q + 2'd1 : floor_q - 2'd1;
        more      = |(pending_q & (state_q == MOVE_UP ? above_m(nf) : below_m(nf)));
        clr_v     = (!estop && state_q == IDLE && pending_q[floor_q]) ? 4'b0001 << floor_q :
                    (step && pending_q[nf]) ? 4'b0001 << nf : 4'b0000;
        pending_d = (pending_q | set_v) & ~clr_v;
    end

    // Scheduling FSM; estop freezes state, floor and timers but not call capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            floor_q    <= 2'd0;
            pending_q  <= 4'd0;
            last_dir_q <= 1'b1;
            travel_q   <= '0;
            door_q     <= '0;
            call_q     <= 1'b0;
        end else begin
            call_q    <= up_or_down[0];
            pending_q <= pending_d;
            if (reload) door_q <= '0;
            else if (!estop) begin
                case (state_q)
                    IDLE:
                        if (pending_q[floor_q]) begin
                            state_q <= DOOR_OPEN;
                            door_q  <= '0;
                        end else if (above || below) begin
                            state_q    <= go_up ? MOVE_UP : MOVE_DOWN;
                            last_dir_q <= go_up;
                            travel_q   <= '0;
                        end
                    MOVE_UP, MOVE_DOWN:
                        if (step) begin
                            floor_q  <= nf;
                            travel_q <= '0;
                            door_q   <= '0;
                            state_q  <= pending_q[nf] ? DOOR_OPEN : more ? state_q : IDLE;
                        end else travel_q <= travel_q + CNT_W'(1);
                    default:
                        if (door_q == CNT_W'(DOOR_CYCLES - 1)) state_q <= IDLE;
                        else door_q <= door_q + CNT_W'(1);
                endcase
            end
        end
    end

    assign current_floor = floor_q;
    assign motor_up      = state_q == MOVE_UP && !estop;
    assign motor_down    = state_q == MOVE_DOWN && !estop;
    assign door_open     = state_q == DOOR_OPEN;
    assign pending       = pending_q;
    assign busy          = state_q != IDLE;

    a_no_wrap: assert property (@(posedge clk) disable iff (rst)
        !(state_q == MOVE_UP && floor_q == 2'd3) && !(state_q == MOVE_DOWN && floor_q == 2'd0));
endmodule
